// File: rtl/bus_ir_arbiter.sv
// bus_ir_arbiter: two fetch requesters share one memory bus, one transaction outstanding.
// Define BUS_IR_ARBITER_RR_EN for round-robin ties; otherwise requester 0 wins ties.
module bus_ir_arbiter #(
    parameter int data_width = 32,
    parameter int addr_width = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req0_addr_valid,
    output logic                  req0_addr_ready,
    input  logic [addr_width-1:0] req0_addr,
    output logic                  req0_data_valid,
    input  logic                  req0_data_ready,
    output logic [data_width-1:0] req0_data,
    input  logic                  req1_addr_valid,
    output logic                  req1_addr_ready,
    input  logic [addr_width-1:0] req1_addr,
    output logic                  req1_data_valid,
    input  logic                  req1_data_ready,
    output logic [data_width-1:0] req1_data,
    output logic                  bus_addr_valid,
    input  logic                  bus_addr_ready,
    output logic [addr_width-1:0] bus_addr,
    input  logic                  bus_data_valid,
    output logic                  bus_data_ready,
    input  logic [data_width-1:0] bus_data
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
    state_t state, state_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic grant_q, grant_d, pick1;
`ifdef BUS_IR_ARBITER_RR_EN
    logic last_q, last_d;
    // A tie goes to whichever requester was not served last.
    assign pick1 = req1_addr_valid && (!req0_addr_valid || !last_q);
    assign last_d = (state == DATA && bus_data_valid && bus_data_ready) ? grant_q : last_q;
    always_ff @(posedge clock or negedge reset)
        if (!reset) last_q <= 1'b1;
        else last_q <= last_d;
`else
    assign pick1 = req1_addr_valid && !req0_addr_valid;
`endif
    assign bus_addr = addr_q;
    assign req0_data = bus_data;
    assign req1_data = bus_data;
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state <= IDLE;
            addr_q <= '0;
            grant_q <= 1'b0;
        end else begin
            state <= state_d;
            addr_q <= addr_d;
            grant_q <= grant_d;
        end
    // Handshake outputs are gated by reset so nothing is offered while it is held low.
    always_comb begin
        state_d = state;
        addr_d = addr_q;
        grant_d = grant_q;
        req0_addr_ready = 1'b0;
        req1_addr_ready = 1'b0;
        req0_data_valid = 1'b0;
        req1_data_valid = 1'b0;
        bus_addr_valid = 1'b0;
        bus_data_ready = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    req0_addr_ready = req0_addr_valid && !pick1;
                    req1_addr_ready = pick1;
                    if (req0_addr_valid || req1_addr_valid) begin
                        state_d = ADDR;
                        addr_d = pick1 ? req1_addr : req0_addr;
                        grant_d = pick1;
                    end
                end
                ADDR: begin
                    bus_addr_valid = 1'b1;
                    if (bus_addr_ready) state_d = DATA;
                end
                DATA: begin
                    req0_data_valid = bus_data_valid && !grant_q;
                    req1_data_valid = bus_data_valid && grant_q;
                    bus_data_ready = grant_q ? req1_data_ready : req0_data_ready;
                    if (bus_data_valid && bus_data_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_ir_arbiter.sv
// tb_bus_ir_arbiter: vector table plus scoreboard of expected bus transactions.
// Honours BUS_IR_ARBITER_RR_EN for the expected tie winners.
module tb_bus_ir_arbiter;
`ifdef BUS_IR_ARBITER_RR_EN
    localparam int RR = 1;
`else
    localparam int RR = 0;
`endif
    logic clock = 1'b0;
    logic reset;
    logic req0_addr_valid, req0_addr_ready, req0_data_valid, req0_data_ready;
    logic req1_addr_valid, req1_addr_ready, req1_data_valid, req1_data_ready;
    logic [31:0] req0_addr, req1_addr, req0_data, req1_data;
    logic bus_addr_valid, bus_addr_ready, bus_data_valid, bus_data_ready;
    logic [31:0] bus_addr, bus_data;

    typedef struct {int w; logic [31:0] addr; logic [31:0] data;} exp_t;
    typedef struct {logic v0, v1; logic [31:0] a0, a1, d; int aw, dw, w;} vec_t;
    exp_t sb[$];
    vec_t tbl[8];
    int checks = 0;
    int errors = 0;

    bus_ir_arbiter dut (
        .clock(clock), .reset(reset),
        .req0_addr_valid(req0_addr_valid), .req0_addr_ready(req0_addr_ready),
        .req0_addr(req0_addr), .req0_data_valid(req0_data_valid),
        .req0_data_ready(req0_data_ready), .req0_data(req0_data),
        .req1_addr_valid(req1_addr_valid), .req1_addr_ready(req1_addr_ready),
        .req1_addr(req1_addr), .req1_data_valid(req1_data_valid),
        .req1_data_ready(req1_data_ready), .req1_data(req1_data),
        .bus_addr_valid(bus_addr_valid), .bus_addr_ready(bus_addr_ready),
        .bus_addr(bus_addr), .bus_data_valid(bus_data_valid),
        .bus_data_ready(bus_data_ready), .bus_data(bus_data)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the accepting posedge.
    task automatic present(input logic v0, input logic v1, input logic [31:0] a0,
                           input logic [31:0] a1, input logic [31:0] d, input int w);
        req0_addr_valid = v0;
        req1_addr_valid = v1;
        req0_addr = a0;
        req1_addr = a1;
        #1;
        chk("req0_addr_ready", 64'(req0_addr_ready), 64'(w == 0));
        chk("req1_addr_ready", 64'(req1_addr_ready), 64'(w == 1));
        chk("bus_addr_valid_idle", 64'(bus_addr_valid), 64'(0));
        sb.push_back('{w, (w == 1) ? a1 : a0, d});
        @(negedge clock);
        if (w == 1) req1_addr_valid = 1'b0;
        else req0_addr_valid = 1'b0;
    endtask

    task automatic serve(input int aw, input int dw);
        exp_t e;
        int got;
        e = sb[0];
        for (int i = 0; i <= aw; i++) begin
            bus_addr_ready = (i == aw);
            #1;
            chk("bus_addr_valid", 64'(bus_addr_valid), 64'(1));
            chk("bus_addr", 64'(bus_addr), 64'(e.addr));
            chk("addr_ready_busy", 64'({req1_addr_ready, req0_addr_ready}), 64'(0));
            chk("bus_data_ready_addr", 64'(bus_data_ready), 64'(0));
            @(negedge clock);
        end
        bus_addr_ready = 1'b0;
        bus_data_valid = 1'b1;
        bus_data = e.data;
        for (int i = 0; i <= dw; i++) begin
            req0_data_ready = (e.w == 1) || (i == dw);
            req1_data_ready = (e.w == 0) || (i == dw);
            #1;
            chk("bus_addr_valid_data", 64'(bus_addr_valid), 64'(0));
            chk("bus_data_ready", 64'(bus_data_ready), 64'(i == dw));
            chk("req0_data_valid", 64'(req0_data_valid), 64'(e.w == 0));
            chk("req1_data_valid", 64'(req1_data_valid), 64'(e.w == 1));
            chk("req0_data", 64'(req0_data), 64'(e.data));
            chk("req1_data", 64'(req1_data), 64'(e.data));
            chk("addr_ready_data", 64'({req1_addr_ready, req0_addr_ready}), 64'(0));
            if (i == dw) begin
                got = (req1_data_valid && req1_data_ready) ? 1 :
                      (req0_data_valid && req0_data_ready) ? 0 : -1;
                chk("deliver_port", 64'(got), 64'(e.w));
                if (sb.size() > 0) void'(sb.pop_front());
            end
            @(negedge clock);
        end
        #1;
        chk("no_redelivery", 64'({req1_data_valid, req0_data_valid, bus_data_ready}), 64'(0));
        bus_data_valid = 1'b0;
        req0_data_ready = 1'b0;
        req1_data_ready = 1'b0;
    endtask

    initial begin
        int n0, n1, w;
        tbl[0] = '{1'b1, 1'b0, 32'h7B, 32'h0, 32'h65, 0, 0, 0};
        tbl[1] = '{1'b0, 1'b1, 32'h0, 32'h55, 32'hAA, 1, 0, 1};
        tbl[2] = '{1'b1, 1'b1, 32'h10, 32'h20, 32'h11, 0, 1, 0};
        tbl[3] = '{1'b1, 1'b1, 32'h30, 32'h40, 32'h22, 1, 0, RR};
        tbl[4] = '{1'b1, 1'b1, 32'h50, 32'h60, 32'h33, 0, 2, 0};
        tbl[5] = '{1'b1, 1'b1, 32'h70, 32'h80, 32'h44, 2, 0, RR};
        tbl[6] = '{1'b1, 1'b0, 32'h1234, 32'h0, 32'h194, 5, 3, 0};
        tbl[7] = '{1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 32'hDEADBEEF, 2, 1, 1};
        reset = 1'b0;
        req0_addr_valid = 1'b1;
        req1_addr_valid = 1'b1;
        req0_addr = 32'h99;
        req1_addr = 32'h98;
        req0_data_ready = 1'b1;
        req1_data_ready = 1'b1;
        bus_addr_ready = 1'b1;
        bus_data_valid = 1'b1;
        bus_data = 32'h0;
        #1;
        chk("rst_outputs", 64'({req0_addr_ready, req1_addr_ready, req0_data_valid,
            req1_data_valid, bus_addr_valid, bus_data_ready}), 64'(0));
        chk("rst_bus_addr", 64'(bus_addr), 64'(0));
        @(negedge clock);
        @(negedge clock);
        req0_addr_valid = 1'b0;
        req1_addr_valid = 1'b0;
        req0_data_ready = 1'b0;
        req1_data_ready = 1'b0;
        bus_addr_ready = 1'b0;
        bus_data_valid = 1'b0;
        reset = 1'b1;
        // Tie right after reset: requester 0 first, requester 1 held and taken next.
        present(1'b1, 1'b1, 32'h10, 32'h20, 32'hA1, 0);
        serve(0, 0);
        present(1'b0, 1'b1, 32'h0, 32'h20, 32'hA2, 1);
        serve(1, 0);
        foreach (tbl[i]) begin
            present(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].a1, tbl[i].d, tbl[i].w);
            serve(tbl[i].aw, tbl[i].dw);
        end
        n0 = 0;
        n1 = 0;
        for (int k = 0; k < 8; k++) begin
            w = (RR == 1) ? k % 2 : int'(k >= 4);
            present(n0 < 4, n1 < 4, 32'h100 + n0, 32'h200 + n1, 32'h1000 + k, w);
            serve(k % 3, k % 2);
            if (w == 1) n1++;
            else n0++;
        end
        present(1'b1, 1'b0, 32'h77, 32'h0, 32'h5A, 0);
        bus_addr_ready = 1'b1;
        @(negedge clock);
        bus_addr_ready = 1'b0;
        bus_data_valid = 1'b1;
        bus_data = 32'h5A;
        req0_addr_valid = 1'b1;
        #1;
        chk("data_before_reset", 64'(req0_data_valid), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_outputs", 64'({req0_addr_ready, req1_addr_ready, req0_data_valid,
            req1_data_valid, bus_addr_valid, bus_data_ready}), 64'(0));
        chk("async_rst_bus_addr", 64'(bus_addr), 64'(0));
        void'(sb.pop_front());
        @(negedge clock);
        req0_addr_valid = 1'b0;
        req0_data_ready = 1'b1;
        req1_data_ready = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("post_rst_no_data", 64'({req1_data_valid, req0_data_valid, bus_data_ready,
                bus_addr_valid}), 64'(0));
            @(negedge clock);
        end
        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
